banked_data_memory_with_lock: RTL and testbench
===============================================

Name: banked_data_memory_with_lock

Overview:
- Multi-bank, multi-port word memory with one lock per bank, replacing the single global-lock data memory.
- Requests are arbitrated per bank: the lowest issue ID wins, and grants are combinational ("flash grant").
- A granted port holds its bank lock until it releases it. Ports hitting different banks proceed in parallel.
- Sits between the SIC issue ports and backing storage, alongside the ALU array.

Parameters:
- MEM_DEPTH, 1024, total words across all banks (multiple of NUM_BANKS).
- NUM_BANKS, 4, bank count (power of 2, at least 2).
- NUM_PORTS, 4, requesting ports.
- ID_WIDTH, 8, issue-ID width.
- DATA_WIDTH, 32, word width (multiple of 8).
- TIMEOUT_CYCLES, 64, forced-release threshold (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr[NUM_PORTS]  in  32  byte address.
- req_read[NUM_PORTS]  in  1  read request.
- req_write[NUM_PORTS]  in  1  write request.
- req_issue_id[NUM_PORTS]  in  ID_WIDTH  priority; lower value wins.
- release_lock[NUM_PORTS]  in  1  release the lock held by this port.
- wdata[NUM_PORTS]  in  DATA_WIDTH  write data.
- byte_en[NUM_PORTS]  in  DATA_WIDTH/8  write byte mask.
- rdata[NUM_PORTS]  out  DATA_WIDTH  read data.
- grant[NUM_PORTS]  out  1  port owns, or is being granted, its target bank.
- bank_busy[NUM_BANKS]  out  1  bank is in LOCKED.
- lock_timeout[NUM_BANKS]  out  1  one-cycle pulse on forced release.

Behaviour:
- Addressing:
  - word = addr[31:2].
  - bank = word[log2(NUM_BANKS)-1:0].
  - row = (word >> log2(NUM_BANKS)) mod (MEM_DEPTH/NUM_BANKS); upper bits are ignored, so addresses wrap.
- A port is requesting when req_read|req_write.
- Per-bank FSM, IDLE/LOCKED, with registers owner_port and owner_valid:
  - IDLE: candidates are the requesting ports targeting this bank that hold no lock elsewhere.
  - IDLE: the winner is the minimum req_issue_id; ties go to the lowest port index.
  - IDLE: the winner's grant is asserted combinationally in the same cycle. On the next edge the bank goes to LOCKED with owner = winner.
  - LOCKED: grant[owner] = 1 while the owner requests this bank; all other requesters to the bank get grant = 0.
  - LOCKED: release_lock[owner] moves the bank to IDLE on the next edge.
  - LOCKED: release_lock from a non-owner is ignored.
  - Release is not bypassed: in the release cycle other ports still see LOCKED, so handover grant appears in the cycle after the release edge.
- A port holds at most one lock. A lock holder requesting a different bank gets grant = 0 there and keeps its existing lock.
- Write: on each rising edge where grant[p] & req_write[p], the bytes of wdata[p] selected by byte_en[p] are written to bank/row. This also applies in the cycle release_lock[p] is asserted.
- Read: rdata[p] is a combinational read of the addressed word when grant[p] & req_read[p], otherwise 0. A same-cycle write becomes visible only after the edge.
- Ports granted different banks in the same cycle operate in parallel.
- The whole design keeps at most one owner per bank.
- Reset, asynchronous and active-high:
  - All banks go to IDLE and owner_valid = 0.
  - Memory contents clear to 0.
  - bank_busy = 0 and lock_timeout = 0.
  - Combinational outputs follow: with every bank IDLE, grant is the arbitration result and rdata is 0 or the read of cleared memory.
- Reset mid-lock drops the lock immediately. A write pending on that edge is discarded.

Optional Feature:
- Macro: BANKED_MEM_LOCK_TIMEOUT_EN.
- Enabled:
  - Each bank has a counter, cleared on entry to LOCKED and incremented each LOCKED cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without a release, the bank is forced to IDLE on the next edge and lock_timeout[bank] pulses high for one cycle.
  - A release in the same cycle takes precedence and produces no pulse.
- Disabled: no counters; lock_timeout is tied to 0; locks are held indefinitely.

Test Plan:
- Same bank contention: P0 writes 0x10 with ID 100 and P1 writes 0x20 with ID 50; both addresses are in bank 0 when NUM_BANKS=4.
  - Required: grant = 0010.
  - After the P1 release edge: grant = 0001.
  - A later read of 0x20 returns 0xBEEF.
- Parallel banks: P0 writes 0x0 (bank 0) with ID 9 and P1 writes 0x4 (bank 1) with ID 3, simultaneously.
  - Required: grant = 0011, bank_busy = 0011 after the edge.
  - Both writes land in the same cycle.
- Tie-break: P2 and P3 both use ID 7 on bank 2.
  - Required: grant = 0100; P3 is granted one cycle after the P2 release.
- Byte mask: write 0xAABBCCDD to 0x8 with byte_en 4'b0101 over a zeroed word.
  - Required: readback 0x00BB00DD.
- Non-owner release and reset:
  - P0 holds bank 3 and P1 pulses release_lock: bank_busy[3] must stay 1.
  - Asserting rst mid-lock: bank_busy = 0 and memory reads 0 immediately.
- Timeout, with the macro defined and TIMEOUT_CYCLES = 4:
  - Hold the lock with no release: lock_timeout pulses four cycles after lock entry and the waiting port is granted next.
  - With the macro undefined, lock_timeout never pulses.

Source files
------------

// File: rtl/banked_data_memory_with_lock.sv
// Banked word memory with one lock per bank and same-cycle grants from per-bank arbitration.
// Define BANKED_MEM_LOCK_TIMEOUT_EN to force-release locks held for TIMEOUT_CYCLES cycles.
//
// Per-bank FSM states:
//   state    | meaning
//   S_IDLE   | no owner; lowest-ID requester is granted combinationally
//   S_LOCKED | owner_port holds the bank until it asserts release_lock
module banked_data_memory_with_lock #(
  parameter int MEM_DEPTH      = 1024,
  parameter int NUM_BANKS      = 4,
  parameter int NUM_PORTS      = 4,
  parameter int ID_WIDTH       = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             addr         [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]    req_read,
  input  logic [NUM_PORTS-1:0]    req_write,
  input  logic [ID_WIDTH-1:0]     req_issue_id [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]    release_lock,
  input  logic [DATA_WIDTH-1:0]   wdata        [NUM_PORTS],
  input  logic [DATA_WIDTH/8-1:0] byte_en      [NUM_PORTS],
  output logic [DATA_WIDTH-1:0]   rdata        [NUM_PORTS],
  output logic [NUM_PORTS-1:0]    grant,
  output logic [NUM_BANKS-1:0]    bank_busy,
  output logic [NUM_BANKS-1:0]    lock_timeout
);

  localparam int ROWS   = MEM_DEPTH / NUM_BANKS;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BYTES  = DATA_WIDTH / 8;

  typedef enum logic {S_IDLE, S_LOCKED} bank_state_t;

  bank_state_t          state_q      [NUM_BANKS];
  bank_state_t          state_d      [NUM_BANKS];
  logic [PORT_W-1:0]    owner_port_q [NUM_BANKS];
  logic [PORT_W-1:0]    owner_port_d [NUM_BANKS];
  logic [NUM_BANKS-1:0] owner_valid_q;
  logic [NUM_BANKS-1:0] owner_valid_d;

  logic [BANK_W-1:0]    port_bank [NUM_PORTS];
  logic [ROW_W-1:0]     port_row  [NUM_PORTS];
  logic [NUM_PORTS-1:0] requesting;
  logic [NUM_PORTS-1:0] holds_lock;

  logic [NUM_BANKS-1:0] win_valid;
  logic [PORT_W-1:0]    win_port [NUM_BANKS];
  logic [ID_WIDTH-1:0]  win_id   [NUM_BANKS];

  logic [NUM_BANKS-1:0]  bank_we;
  logic [ROW_W-1:0]      bank_row   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_mask  [NUM_BANKS];
  logic [DATA_WIDTH-1:0] mem_rd     [NUM_BANKS][ROWS];

  assign requesting = req_read | req_write;

  // Low word bits pick the bank so consecutive words spread across banks.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [29:0] word;
    logic [29:0] row_full;
    logic        unused_bits;
    assign word         = addr[p][31:2];
    assign port_bank[p] = word[BANK_W-1:0];
    assign row_full     = (word >> BANK_W) % 30'(ROWS);
    assign port_row[p]  = row_full[ROW_W-1:0];
    assign unused_bits  = ^{addr[p][1:0], row_full};
  end

  always_comb begin
    holds_lock = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (owner_valid_q[b]) holds_lock[owner_port_q[b]] = 1'b1;
    end
  end

  // Strict less-than keeps the lowest port index on an ID tie.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      win_valid[b] = 1'b0;
      win_port[b]  = '0;
      win_id[b]    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (requesting[p] && !holds_lock[p] && port_bank[p] == BANK_W'(b) &&
            (!win_valid[b] || req_issue_id[p] < win_id[b])) begin
          win_valid[b] = 1'b1;
          win_port[b]  = PORT_W'(p);
          win_id[b]    = req_issue_id[p];
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (requesting[p]) begin
        if (state_q[port_bank[p]] == S_LOCKED)
          grant[p] = (owner_port_q[port_bank[p]] == PORT_W'(p));
        else
          grant[p] = win_valid[port_bank[p]] && (win_port[port_bank[p]] == PORT_W'(p));
      end
    end
  end

`ifdef BANKED_MEM_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]     cnt_q [NUM_BANKS];
  logic [CNT_W-1:0]     cnt_d [NUM_BANKS];
  logic [NUM_BANKS-1:0] timeout_d;
  logic [NUM_BANKS-1:0] timeout_q;
`endif

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      state_d[b]      = state_q[b];
      owner_port_d[b] = owner_port_q[b];
`ifdef BANKED_MEM_LOCK_TIMEOUT_EN
      cnt_d[b]     = cnt_q[b];
      timeout_d[b] = 1'b0;
`endif
      case (state_q[b])
        S_IDLE: begin
          if (win_valid[b]) begin
            state_d[b]      = S_LOCKED;
            owner_port_d[b] = win_port[b];
`ifdef BANKED_MEM_LOCK_TIMEOUT_EN
            cnt_d[b] = '0;
`endif
          end
        end
        S_LOCKED: begin
          if (release_lock[owner_port_q[b]]) begin
            state_d[b] = S_IDLE;
          end
`ifdef BANKED_MEM_LOCK_TIMEOUT_EN
          else if (cnt_q[b] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d[b]   = S_IDLE;
            timeout_d[b] = 1'b1;
          end else begin
            cnt_d[b] = cnt_q[b] + 1'b1;
          end
`endif
        end
        default: state_d[b] = S_IDLE;
      endcase
      owner_valid_d[b] = (state_d[b] == S_LOCKED);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_valid_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b]      <= S_IDLE;
        owner_port_q[b] <= '0;
      end
    end else begin
      owner_valid_q <= owner_valid_d;
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b]      <= state_d[b];
        owner_port_q[b] <= owner_port_d[b];
      end
    end
  end

`ifdef BANKED_MEM_LOCK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) cnt_q[b] <= '0;
    end else begin
      timeout_q <= timeout_d;
      for (int b = 0; b < NUM_BANKS; b++) cnt_q[b] <= cnt_d[b];
    end
  end
  assign lock_timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign lock_timeout   = '0;
`endif

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) bank_busy[b] = (state_q[b] == S_LOCKED);
  end

  // Grants are unique per bank, so each bank sees at most one writer per cycle.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_we[b]    = 1'b0;
      bank_row[b]   = '0;
      bank_wdata[b] = '0;
      bank_mask[b]  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant[p] && req_write[p] && port_bank[p] == BANK_W'(b)) begin
          bank_we[b]    = 1'b1;
          bank_row[b]   = port_row[p];
          bank_wdata[b] = wdata[p];
          for (int k = 0; k < BYTES; k++) bank_mask[b][8*k +: 8] = {8{byte_en[p][k]}};
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_WIDTH-1:0] word_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          word_q <= '0;
        else if (bank_we[b] && bank_row[b] == ROW_W'(r))
          word_q <= (word_q & ~bank_mask[b]) | (bank_wdata[b] & bank_mask[b]);
      end
      assign mem_rd[b][r] = word_q;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rdata[p] = '0;
      if (grant[p] && req_read[p]) rdata[p] = mem_rd[port_bank[p]][port_row[p]];
    end
  end

endmodule

// File: tb/tb_banked_data_memory_with_lock.sv
// Directed bench for banked_data_memory_with_lock: a vector table for arbitration,
// locking and data, then hand sequences for reset mid-lock and lock timeout.
module tb_banked_data_memory_with_lock;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr         [4];
  logic [3:0]  req_read, req_write, release_lock;
  logic [7:0]  req_issue_id [4];
  logic [31:0] wdata        [4];
  logic [3:0]  byte_en      [4];
  logic [31:0] rdata        [4];
  logic [3:0]  grant, bank_busy, lock_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banked_data_memory_with_lock #(
    .MEM_DEPTH(1024), .NUM_BANKS(4), .NUM_PORTS(4), .ID_WIDTH(8),
    .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .req_read(req_read), .req_write(req_write),
    .req_issue_id(req_issue_id), .release_lock(release_lock), .wdata(wdata),
    .byte_en(byte_en), .rdata(rdata), .grant(grant), .bank_busy(bank_busy),
    .lock_timeout(lock_timeout)
  );

  typedef struct packed {
    logic [3:0][31:0] addr;
    logic [3:0]       rd;
    logic [3:0]       wr;
    logic [3:0][7:0]  id;
    logic [3:0][31:0] wd;
    logic [3:0][3:0]  be;
    logic [3:0]       rel;
    logic [3:0]       exp_grant;
    logic [3:0]       exp_busy;
    logic [3:0][31:0] exp_rdata;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_port(input int i, input int p, input logic [31:0] a, input logic rd,
                          input logic wr, input logic [7:0] id, input logic [31:0] wd,
                          input logic [3:0] be, input logic rel);
    vecs[i].addr[p] = a;
    vecs[i].rd[p]   = rd;
    vecs[i].wr[p]   = wr;
    vecs[i].id[p]   = id;
    vecs[i].wd[p]   = wd;
    vecs[i].be[p]   = be;
    vecs[i].rel[p]  = rel;
  endtask

  task automatic set_exp(input int i, input logic [3:0] g, input logic [3:0] busy,
                         input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] r3);
    vecs[i].exp_grant    = g;
    vecs[i].exp_busy     = busy;
    vecs[i].exp_rdata[0] = r0;
    vecs[i].exp_rdata[1] = r1;
    vecs[i].exp_rdata[2] = r2;
    vecs[i].exp_rdata[3] = r3;
  endtask

  task automatic drive_idle();
    for (int p = 0; p < 4; p++) begin
      addr[p] = '0; req_issue_id[p] = '0; wdata[p] = '0; byte_en[p] = 4'hF;
    end
    req_read = '0; req_write = '0; release_lock = '0;
  endtask

  task automatic apply(input int i);
    for (int p = 0; p < 4; p++) begin
      addr[p]         = vecs[i].addr[p];
      req_read[p]     = vecs[i].rd[p];
      req_write[p]    = vecs[i].wr[p];
      req_issue_id[p] = vecs[i].id[p];
      wdata[p]        = vecs[i].wd[p];
      byte_en[p]      = vecs[i].be[p];
      release_lock[p] = vecs[i].rel[p];
    end
  endtask

  initial begin
    for (int i = 0; i < NV; i++) vecs[i] = '0;
    // same-bank contention: P1 (ID 50) beats P0 (ID 100) on bank 0
    set_port(0, 0, 32'h10, 0, 1, 100, 32'h1111, 4'hF, 0);
    set_port(0, 1, 32'h20, 0, 1, 50, 32'hBEEF, 4'hF, 0);
    set_exp(0, 4'b0010, 4'b0000, 0, 0, 0, 0);
    set_port(1, 0, 32'h10, 0, 1, 100, 32'h1111, 4'hF, 0);
    set_port(1, 1, 32'h20, 0, 1, 50, 32'hBEEF, 4'hF, 1);
    set_exp(1, 4'b0010, 4'b0001, 0, 0, 0, 0);
    set_port(2, 0, 32'h10, 0, 1, 100, 32'h1111, 4'hF, 0);
    set_exp(2, 4'b0001, 4'b0000, 0, 0, 0, 0);
    set_port(3, 0, 32'h10, 0, 1, 100, 32'h1111, 4'hF, 1);
    set_exp(3, 4'b0001, 4'b0001, 0, 0, 0, 0);
    set_port(4, 2, 32'h20, 1, 0, 1, 0, 4'hF, 0);
    set_exp(4, 4'b0100, 4'b0000, 0, 0, 32'hBEEF, 0);
    set_port(5, 2, 32'h20, 1, 0, 1, 0, 4'hF, 1);
    set_exp(5, 4'b0100, 4'b0001, 0, 0, 32'hBEEF, 0);
    // parallel banks 0 and 1
    set_port(6, 0, 32'h0, 0, 1, 9, 32'hA0A0A0A0, 4'hF, 0);
    set_port(6, 1, 32'h4, 0, 1, 3, 32'hB1B1B1B1, 4'hF, 0);
    set_exp(6, 4'b0011, 4'b0000, 0, 0, 0, 0);
    set_port(7, 0, 32'h0, 0, 1, 9, 32'hA0A0A0A0, 4'hF, 1);
    set_port(7, 1, 32'h4, 0, 1, 3, 32'hB1B1B1B1, 4'hF, 1);
    set_exp(7, 4'b0011, 4'b0011, 0, 0, 0, 0);
    set_port(8, 0, 32'h0, 1, 0, 9, 0, 4'hF, 0);
    set_port(8, 1, 32'h4, 1, 0, 3, 0, 4'hF, 0);
    set_exp(8, 4'b0011, 4'b0000, 32'hA0A0A0A0, 32'hB1B1B1B1, 0, 0);
    set_port(9, 0, 32'h0, 1, 0, 9, 0, 4'hF, 1);
    set_port(9, 1, 32'h4, 1, 0, 3, 0, 4'hF, 1);
    set_exp(9, 4'b0011, 4'b0011, 32'hA0A0A0A0, 32'hB1B1B1B1, 0, 0);
    // byte mask over a zeroed word
    set_port(10, 0, 32'h8, 0, 1, 0, 32'hAABBCCDD, 4'b0101, 0);
    set_exp(10, 4'b0001, 4'b0000, 0, 0, 0, 0);
    set_port(11, 0, 32'h8, 1, 0, 0, 0, 4'hF, 1);
    set_exp(11, 4'b0001, 4'b0100, 32'h00BB00DD, 0, 0, 0);
    // tie-break on bank 2
    set_port(12, 2, 32'h8, 1, 0, 7, 0, 4'hF, 0);
    set_port(12, 3, 32'h8, 1, 0, 7, 0, 4'hF, 0);
    set_exp(12, 4'b0100, 4'b0000, 0, 0, 32'h00BB00DD, 0);
    set_port(13, 2, 32'h8, 1, 0, 7, 0, 4'hF, 1);
    set_port(13, 3, 32'h8, 1, 0, 7, 0, 4'hF, 0);
    set_exp(13, 4'b0100, 4'b0100, 0, 0, 32'h00BB00DD, 0);
    set_port(14, 3, 32'h8, 1, 0, 7, 0, 4'hF, 0);
    set_exp(14, 4'b1000, 4'b0000, 0, 0, 0, 32'h00BB00DD);
    set_port(15, 3, 32'h8, 1, 0, 7, 0, 4'hF, 1);
    set_exp(15, 4'b1000, 4'b0100, 0, 0, 0, 32'h00BB00DD);
    // P0 locks bank 3; other-bank request and non-owner release must have no effect
    set_port(16, 0, 32'hC, 0, 1, 5, 32'h55, 4'hF, 0);
    set_exp(16, 4'b0001, 4'b0000, 0, 0, 0, 0);
    set_port(17, 0, 32'h0, 1, 0, 5, 0, 4'hF, 0);
    set_port(17, 1, 32'hC, 1, 0, 0, 0, 4'hF, 1);
    set_exp(17, 4'b0000, 4'b1000, 0, 0, 0, 0);
    set_exp(18, 4'b0000, 4'b1000, 0, 0, 0, 0);

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_busy", 32'(bank_busy), 32'h0);
    check("reset_timeout", 32'(lock_timeout), 32'h0);
    check("reset_rdata0", rdata[0], 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      apply(i);
      #2;
      check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("v%0d_busy", i), 32'(bank_busy), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d_timeout", i), 32'(lock_timeout), 32'h0);
      for (int p = 0; p < 4; p++)
        check($sformatf("v%0d_rdata%0d", i, p), rdata[p], vecs[i].exp_rdata[p]);
      @(posedge clk); #1;
    end

    // reset while P0 holds bank 3 with a write pending
    drive_idle();
    addr[0] = 32'hC; req_read[0] = 1'b1; req_write[0] = 1'b1; wdata[0] = 32'hFFFFFFFF;
    #2;
    check("prerst_busy", 32'(bank_busy), 32'h8);
    check("prerst_rdata0", rdata[0], 32'h55);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(bank_busy), 32'h0);
    check("rst_grant", 32'(grant), 32'h1);
    check("rst_rdata0", rdata[0], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    addr[1] = 32'hC; req_read[1] = 1'b1;
    addr[2] = 32'h20; req_read[2] = 1'b1;
    #2;
    check("postrst_grant", 32'(grant), 32'h6);
    check("postrst_rdata1", rdata[1], 32'h0);
    check("postrst_rdata2", rdata[2], 32'h0);
    @(posedge clk); #1;
    release_lock[1] = 1'b1; release_lock[2] = 1'b1;
    @(posedge clk); #1;

    // lock held with no release; P1 waits on the same bank
    drive_idle();
    addr[0] = 32'h4; req_write[0] = 1'b1; req_issue_id[0] = 8'd1; wdata[0] = 32'h77;
    #2;
    check("to_entry_grant", 32'(grant), 32'h1);
    @(posedge clk); #1;
    addr[1] = 32'h4; req_read[1] = 1'b1; req_issue_id[1] = 8'd0;
    for (int c = 1; c <= 4; c++) begin
      #2;
      check($sformatf("to_c%0d_timeout", c), 32'(lock_timeout), 32'h0);
      check($sformatf("to_c%0d_busy", c), 32'(bank_busy), 32'h2);
      check($sformatf("to_c%0d_grant", c), 32'(grant), 32'h1);
      @(posedge clk); #1;
    end
    #2;
`ifdef BANKED_MEM_LOCK_TIMEOUT_EN
    check("to_c5_timeout", 32'(lock_timeout), 32'h2);
    check("to_c5_busy", 32'(bank_busy), 32'h0);
    check("to_c5_grant", 32'(grant), 32'h2);
    check("to_c5_rdata1", rdata[1], 32'h77);
    @(posedge clk); #1; #2;
    check("to_c6_timeout", 32'(lock_timeout), 32'h0);
    check("to_c6_busy", 32'(bank_busy), 32'h2);
    check("to_c6_grant", 32'(grant), 32'h2);
`else
    check("to_c5_timeout", 32'(lock_timeout), 32'h0);
    check("to_c5_busy", 32'(bank_busy), 32'h2);
    check("to_c5_grant", 32'(grant), 32'h1);
    @(posedge clk); #1; #2;
    check("to_c6_timeout", 32'(lock_timeout), 32'h0);
    check("to_c6_grant", 32'(grant), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
